// File: rtl/pci_pkg.sv
// Shared definitions for the PCI burst initiator: command codes, completion
// status encodings and the transaction state enum.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic [1:0] STATUS_OK    = 2'b00;
    localparam logic [1:0] STATUS_ABORT = 2'b01;
    localparam logic [1:0] STATUS_STOP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ABORT = 3'd3,
        TURN  = 3'd4
    } pci_state_e;

    // Bit 0 of a PCI command distinguishes write from read for memory cycles.
    function automatic logic cmd_is_write(input logic [3:0] cmd);
        return cmd[0];
    endfunction

endpackage

// File: rtl/pci_devsel_timer.sv
// DEVSEL watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT-th enabled cycle is reached.
module pci_devsel_timer #(
    parameter int TIMEOUT = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_timeout) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_timeout = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pci_master_burst.sv
// PCI initiator turning one local request into an address phase plus a burst of
// data phases. Optional even parity on PAR/PAR_OE when PCI_MASTER_PARITY_EN is defined.
module pci_master_burst
    import pci_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int DEVSEL_TO = 5,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [31:0]       REQ_ADDR,
    input  logic [3:0]        REQ_CMD,
    input  logic [LEN_W-1:0]  REQ_LEN,
    input  logic [3:0]        REQ_BE,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WDATA_VALID,
    output logic              WDATA_READY,
    output logic [DATA_W-1:0] RDATA,
    output logic              RDATA_VALID,
    output logic              DONE,
    output logic [1:0]        STATUS,
    output logic [LEN_W-1:0]  XFER_CNT,
    output logic              FRAME,
    output logic              IRDY,
    input  logic              T_RDY,
    input  logic              DEVSEL,
    input  logic              STOP,
    output logic [3:0]        C_BE,
    output logic [31:0]       AD_O,
    input  logic [31:0]       AD_I,
    output logic              AD_OE,
`ifdef PCI_MASTER_PARITY_EN
    output logic              PAR,
    output logic              PAR_OE,
`endif
    output logic [2:0]        DBG_STATE
);

    // Handshakes: a request is taken on a clock where REQ_VALID && REQ_READY;
    // a write word is consumed on a clock where WDATA_READY is high (WDATA_VALID
    // must stay high until then); RDATA is valid only in cycles with RDATA_VALID.

    pci_state_e        r_state, w_next;
    logic [31:0]       r_addr;
    logic [3:0]        r_cmd, r_be;
    logic [LEN_W-1:0]  r_len, r_cnt, w_req_len;
    logic [1:0]        r_status;
    logic              r_stop, r_irdy_hold, r_rdata_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              w_write, w_irdy_on, w_xfer, w_last, w_final, w_stop_hit;
    logic              w_tmr_clr, w_tmr_en, w_timeout;

    assign w_write   = cmd_is_write(r_cmd);
    assign w_req_len = (REQ_LEN == '0) ? LEN_W'(1) :
                       (REQ_LEN > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : REQ_LEN;
    // Once IRDY is asserted it is held until the phase completes.
    assign w_irdy_on  = (r_state == DATA) && (r_stop || r_irdy_hold || !w_write || WDATA_VALID);
    assign w_xfer     = w_irdy_on && !T_RDY;
    assign w_last     = (r_cnt == r_len - LEN_W'(1));
    assign w_final    = w_xfer && w_last;
    assign w_stop_hit = (r_state == DATA) && !r_stop && !STOP && !DEVSEL;
    assign w_tmr_clr  = (r_state == ADDR);
    assign w_tmr_en   = (r_state == DATA) && DEVSEL;

    pci_devsel_timer #(.TIMEOUT(DEVSEL_TO)) u_devsel_timer (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (REQ_VALID) w_next = ADDR;
            ADDR:  w_next = DATA;
            DATA: begin
                // A completing final phase wins over a simultaneous STOP.
                if (w_final) begin
                    w_next = TURN;
                end else if (r_stop) begin
                    if (!STOP || w_xfer) w_next = TURN;
                end else if (w_stop_hit) begin
                    if (w_xfer) w_next = TURN;
                end else if (w_timeout) begin
                    w_next = ABORT;
                end
            end
            ABORT: w_next = TURN;
            TURN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr        <= '0;
            r_cmd         <= '0;
            r_be          <= 4'hF;
            r_len         <= '0;
            r_cnt         <= '0;
            r_status      <= STATUS_OK;
            r_stop        <= 1'b0;
            r_irdy_hold   <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            case (r_state)
                IDLE: if (REQ_VALID) begin
                    r_addr <= REQ_ADDR;
                    r_cmd  <= REQ_CMD;
                    r_be   <= REQ_BE;
                    r_len  <= w_req_len;
                end
                ADDR: begin
                    r_cnt       <= '0;
                    r_status    <= STATUS_OK;
                    r_stop      <= 1'b0;
                    r_irdy_hold <= 1'b0;
                end
                DATA: begin
                    if (w_xfer) r_cnt <= r_cnt + LEN_W'(1);
                    if (w_xfer && !w_write) begin
                        r_rdata       <= AD_I;
                        r_rdata_valid <= 1'b1;
                    end
                    r_irdy_hold <= w_irdy_on && !w_xfer;
                    if (w_stop_hit) r_stop <= 1'b1;
                    if (w_final) r_status <= STATUS_OK;
                    else if (w_stop_hit || r_stop) r_status <= STATUS_STOP;
                end
                ABORT: begin
                    r_status <= STATUS_ABORT;
                    r_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        REQ_READY = 1'b0;
        FRAME     = 1'b1;
        IRDY      = 1'b1;
        AD_OE     = 1'b0;
        AD_O      = '0;
        C_BE      = 4'hF;
        DONE      = 1'b0;
        case (r_state)
            IDLE: REQ_READY = 1'b1;
            ADDR: begin
                FRAME = 1'b0;
                AD_OE = 1'b1;
                AD_O  = r_addr;
                C_BE  = r_cmd;
            end
            DATA: begin
                C_BE  = r_be;
                AD_OE = w_write;
                AD_O  = w_write ? WDATA : '0;
                IRDY  = !w_irdy_on;
                FRAME = r_stop || (w_last && w_irdy_on);
            end
            ABORT: IRDY = 1'b0;
            TURN:  DONE = 1'b1;
            default: ;
        endcase
    end

    assign WDATA_READY = w_xfer && w_write;
    assign RDATA       = r_rdata;
    assign RDATA_VALID = r_rdata_valid;
    assign STATUS      = r_status;
    assign XFER_CNT    = r_cnt;
    assign DBG_STATE   = r_state;

`ifdef PCI_MASTER_PARITY_EN
    logic r_par, r_par_oe;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_par    <= 1'b0;
            r_par_oe <= 1'b0;
        end else begin
            r_par    <= ^{AD_O, C_BE};
            r_par_oe <= AD_OE;
        end
    end

    assign PAR    = r_par;
    assign PAR_OE = r_par_oe;
`endif

endmodule

// File: tb/tb_pci_master_burst.sv
// Bench for pci_master_burst: a behavioural PCI target plus local-side driver,
// with expected results derived from the transaction's target plan.
module tb_pci_master_burst;
    import pci_pkg::*;

    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;
    localparam int DEVSEL_TO = 5;
    localparam int LEN_W     = $clog2(MAX_BURST + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [31:0]       req_addr;
    logic [3:0]        req_cmd, req_be;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wdata, rdata;
    logic              wdata_valid, wdata_ready, rdata_valid, done;
    logic [1:0]        status;
    logic [LEN_W-1:0]  xfer_cnt;
    logic              frame, irdy, t_rdy, devsel, stop, ad_oe;
    logic [3:0]        c_be;
    logic [31:0]       ad_o, ad_i;
    logic [2:0]        dbg_state;

    logic [DATA_W-1:0] exp_q[$];
    int                total = 0;
    int                bad = 0;
    bit                force_wd = 1'b0;
    logic [31:0]       forced_wd = '0;

    pci_master_burst #(
        .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .DEVSEL_TO(DEVSEL_TO), .LEN_W(LEN_W)
    ) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_ADDR(req_addr), .REQ_CMD(req_cmd), .REQ_LEN(req_len), .REQ_BE(req_be),
        .WDATA(wdata), .WDATA_VALID(wdata_valid), .WDATA_READY(wdata_ready),
        .RDATA(rdata), .RDATA_VALID(rdata_valid), .DONE(done), .STATUS(status),
        .XFER_CNT(xfer_cnt), .FRAME(frame), .IRDY(irdy), .T_RDY(t_rdy),
        .DEVSEL(devsel), .STOP(stop), .C_BE(c_be), .AD_O(ad_o), .AD_I(ad_i),
        .AD_OE(ad_oe), .DBG_STATE(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        req_valid   = 1'b0;
        wdata_valid = 1'b0;
        wdata       = '0;
        t_rdy       = 1'b1;
        devsel      = 1'b1;
        stop        = 1'b1;
        ad_i        = '0;
    endtask

    // One transaction. The target claims it if has_devsel, inserts wait_n wait
    // states before phase wait_ph, and signals STOP at phase stop_ph (with or
    // without data). The local side holds WDATA_VALID low gap_n clocks before phase gap_ph.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] cmd, input int req_ln,
                           input logic [3:0] be, input bit has_devsel, input int stop_ph,
                           input bit stop_data, input int wait_ph, input int wait_n,
                           input int gap_ph, input int gap_n);
        int          elen, exp_cnt, tp, cip, cyc, addr_cyc, wr_pulses, rd_pulses;
        logic [1:0]  exp_st;
        logic [31:0] wd [MAX_BURST];
        logic [31:0] rd [MAX_BURST];
        bit          wr, taken, in_data, stopping, done_seen, finished;
        wr = cmd[0];
        taken = 0; in_data = 0; stopping = 0; done_seen = 0; finished = 0;
        tp = 0; cip = 0; cyc = 0; addr_cyc = 0; wr_pulses = 0; rd_pulses = 0;

        // Reference outcome from the target plan.
        elen = (req_ln == 0) ? 1 : (req_ln > MAX_BURST) ? MAX_BURST : req_ln;
        if (!has_devsel) begin
            exp_cnt = 0; exp_st = STATUS_ABORT;
        end else if (stop_ph >= 1 && stop_ph <= elen) begin
            if (stop_data) begin
                exp_cnt = stop_ph;
                exp_st  = (stop_ph == elen) ? STATUS_OK : STATUS_STOP;
            end else begin
                exp_cnt = stop_ph - 1;
                exp_st  = STATUS_STOP;
            end
        end else begin
            exp_cnt = elen; exp_st = STATUS_OK;
        end
        for (int p = 0; p < MAX_BURST; p++) begin
            wd[p] = $urandom;
            rd[p] = $urandom;
        end
        if (force_wd) wd[0] = forced_wd;
        exp_q.delete();
        for (int p = 0; p < exp_cnt; p++) exp_q.push_back(wr ? wd[p] : rd[p]);

        while (!finished && cyc < 200) begin
            @(posedge clk); #1;
            req_valid = !taken;
            req_addr  = addr;
            req_cmd   = cmd;
            req_len   = LEN_W'(req_ln);
            req_be    = be;
            devsel = 1'b1; t_rdy = 1'b1; stop = 1'b1; ad_i = '0;
            if (in_data && has_devsel) begin
                devsel = 1'b0;
                ad_i   = (tp < elen) ? rd[tp] : '0;
                if (stopping) begin
                    stop = 1'b0;
                end else if (tp < elen && cip >= ((tp + 1 == wait_ph) ? wait_n : 0)) begin
                    t_rdy = 1'b0;
                    if (tp + 1 == stop_ph) begin
                        stop = 1'b0;
                        if (!stop_data) t_rdy = 1'b1;
                    end
                end
            end
            wdata       = (tp < elen) ? wd[tp] : '0;
            wdata_valid = wr && in_data && tp < elen && cip >= ((tp + 1 == gap_ph) ? gap_n : 0);

            @(negedge clk);
            cyc++;
            if (in_data && !done_seen) begin
                if (!irdy && !t_rdy) begin
                    check("data_be", c_be, be);
                    if (wr) begin
                        if (exp_q.size() > 0) check("wr_ad", ad_o, exp_q.pop_front());
                        else check("spurious_wr", 1, 0);
                        check("wr_ready", wdata_ready, 1);
                        check("wr_ad_oe", ad_oe, 1);
                    end else begin
                        check("rd_ad_oe", ad_oe, 0);
                    end
                    if (stop) check("frame_at_phase", frame, (tp == elen - 1) ? 1 : 0);
                    else stopping = 1;
                    tp++;
                    cip = 0;
                end else begin
                    if (wr && !wdata_valid && !stopping && tp < elen) check("irdy_wait", irdy, 1);
                    if (!stop) stopping = 1;
                    cip++;
                end
                if (!has_devsel && cyc == addr_cyc + DEVSEL_TO + 1) begin
                    check("abort_frame", frame, 1);
                    check("abort_irdy", irdy, 0);
                end
            end
            if (rdata_valid) begin
                rd_pulses++;
                if (exp_q.size() > 0) check("rd_data", rdata, exp_q.pop_front());
                else check("spurious_rd", 1, 0);
            end
            if (wdata_ready) wr_pulses++;
            if (done_seen) begin
                check("ready_after_turn", req_ready, 1);
                check("idle_frame", frame, 1);
                finished = 1;
            end else if (done) begin
                done_seen = 1;
                check("status", status, exp_st);
                check("xfer_cnt", xfer_cnt, exp_cnt);
                check("turn_ready", req_ready, 0);
                check("turn_bus", {frame, irdy, ad_oe, c_be}, {1'b1, 1'b1, 1'b0, 4'hF});
                if (!has_devsel) check("abort_latency", cyc - addr_cyc, DEVSEL_TO + 2);
            end
            if (taken && !in_data && !frame) begin
                check("addr_ad", ad_o, addr);
                check("addr_cmd", c_be, cmd);
                check("addr_oe", ad_oe, 1);
                in_data  = 1;
                addr_cyc = cyc;
            end
            if (!taken && req_ready) taken = 1;
        end

        check("done_seen", done_seen, 1);
        check("phases", tp, exp_cnt);
        check("rd_pulses", rd_pulses, wr ? 0 : exp_cnt);
        check("wr_pulses", wr_pulses, wr ? exp_cnt : 0);
        check("sb_empty", exp_q.size(), 0);
        drive_idle();
    endtask

    initial begin
        int rl, sp, gp, gn;
        rst = 1'b1;
        drive_idle();
        req_addr = '0; req_cmd = '0; req_len = '0; req_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frame", frame, 1);
        check("rst_irdy", irdy, 1);
        check("rst_ad_oe", ad_oe, 0);
        check("rst_c_be", c_be, 4'hF);
        check("rst_ad_o", ad_o, 0);
        check("rst_flags", {done, rdata_valid, wdata_ready}, 3'b000);
        check("rst_status", status, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_ready", req_ready, 1);

        // Single-phase write of 0000000E to address 0.
        force_wd = 1'b1; forced_wd = 32'h0000_000E;
        run_txn(32'h0, CMD_MEM_WR, 1, 4'h0, 1, 0, 0, 0, 0, 0, 0);
        force_wd = 1'b0;
        // Read burst of 4 with two target wait states before phase 3.
        run_txn($urandom, CMD_MEM_RD, 4, 4'h0, 1, 0, 0, 3, 2, 0, 0);
        // Write burst of 3 with the local side stalling two clocks before phase 2.
        run_txn($urandom, CMD_MEM_WR, 3, 4'h3, 1, 0, 0, 0, 0, 2, 2);
        // No DEVSEL: master abort.
        run_txn($urandom, CMD_MEM_RD, 2, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        run_txn($urandom, CMD_MEM_WR, 4, 4'h0, 0, 0, 0, 0, 0, 1, 2);
        // Target disconnect with data at phase 3 of 8.
        run_txn($urandom, CMD_MEM_RD, 8, 4'h0, 1, 3, 1, 0, 0, 0, 0);
        // Target stop without data, and stop coinciding with the final phase.
        run_txn($urandom, CMD_MEM_RD, 5, 4'h5, 1, 2, 0, 2, 1, 0, 0);
        run_txn($urandom, CMD_MEM_WR, 2, 4'h0, 1, 2, 1, 0, 0, 0, 0);
        // Length boundaries: 0 behaves as 1, oversize clamps to MAX_BURST.
        run_txn($urandom, CMD_MEM_WR, 0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
        run_txn($urandom, CMD_MEM_RD, 12, 4'h0, 1, 0, 0, 5, 1, 0, 0);

        // Reset during phase 2 of a 4-phase write.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = $urandom; req_cmd = CMD_MEM_WR; req_len = LEN_W'(4);
        req_be = 4'h0; devsel = 1'b0; t_rdy = 1'b0; stop = 1'b1;
        wdata_valid = 1'b1; wdata = $urandom;
        @(negedge clk);
        check("rst_t_ready", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_t_addr", frame, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_t_ph1", {irdy, wdata_ready}, 2'b01);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_t_ph2_frame", frame, 0);
        @(posedge clk); #1 rst = 1'b0;
        drive_idle();
        @(negedge clk);
        check("rst_t_release", {frame, irdy, ad_oe}, 3'b110);
        check("rst_t_ready_after", req_ready, 1);
        check("rst_t_xfer_cnt", xfer_cnt, 0);
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("rst_t_no_done", dones, 0);
        end

        // Randomized transactions.
        for (int n = 0; n < 14; n++) begin
            rl = $urandom_range(0, MAX_BURST + 2);
            sp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, MAX_BURST) : 0;
            gp = $urandom_range(1, MAX_BURST);
            gn = (gp == sp) ? 0 : $urandom_range(0, 3);
            run_txn($urandom, ($urandom_range(0, 1) == 1) ? CMD_MEM_WR : CMD_MEM_RD, rl,
                    4'($urandom_range(0, 15)), $urandom_range(0, 4) != 0, sp,
                    1'($urandom_range(0, 1)), $urandom_range(1, MAX_BURST),
                    $urandom_range(0, 3), gp, gn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
